ddram_arbiter: RTL and testbench

//  Shares the single MiSTer DDRAM port between two requesters: video fetch (burst reads, high priority)
//  and CPU/loader (single-beat read or write). Sits between the core and the emu DDRAM_* pins.

---
 rtl/ddram_arbiter_if.sv | 46 ++++
 rtl/ddram_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_ddram_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddram_arbiter_if.sv
// Signal bundle between ddram_arbiter and its surroundings (video fetch, CPU/loader, DDRAM pins).
// The arbiter takes the slave modport; the core and memory side take the master modport.
interface ddram_arbiter_if;
    logic        vid_req;
    logic [28:0] vid_addr;
    logic        vid_ack;
    logic        vid_valid;
    logic [63:0] vid_data;
    logic        vid_done;

    logic        cpu_req;
    logic        cpu_we;
    logic [28:0] cpu_addr;
    logic [63:0] cpu_wdata;
    logic [7:0]  cpu_be;
    logic [63:0] cpu_rdata;
    logic        cpu_done;

    logic        ddram_busy;
    logic [63:0] ddram_dout;
    logic        ddram_dout_rdy;
    logic [7:0]  ddram_burstcnt;
    logic [28:0] ddram_addr;
    logic        ddram_rd;
    logic        ddram_we;
    logic [63:0] ddram_din;
    logic [7:0]  ddram_be;

    modport slave (
        input  vid_req, vid_addr,
        output vid_ack, vid_valid, vid_data, vid_done,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        output cpu_rdata, cpu_done,
        input  ddram_busy, ddram_dout, ddram_dout_rdy,
        output ddram_burstcnt, ddram_addr, ddram_rd, ddram_we, ddram_din, ddram_be
    );

    modport master (
        output vid_req, vid_addr,
        input  vid_ack, vid_valid, vid_data, vid_done,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        input  cpu_rdata, cpu_done,
        output ddram_busy, ddram_dout, ddram_dout_rdy,
        input  ddram_burstcnt, ddram_addr, ddram_rd, ddram_we, ddram_din, ddram_be
    );
endinterface

// File: rtl/ddram_arbiter.sv
// Shares the MiSTer DDRAM port between video burst reads (priority) and CPU single beats.
// Define DDRAM_ARB_STATS_EN to add grant and busy-stall statistics counters.
module ddram_arbiter #(
    parameter int VID_BURST  = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    ddram_arbiter_if.slave  bus
`ifdef DDRAM_ARB_STATS_EN
    ,
    output logic [31:0]     stat_vid_grants,
    output logic [31:0]     stat_cpu_grants,
    output logic [31:0]     stat_busy_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE_RD = 2'd1,
        ISSUE_WR = 2'd2,
        RD_WAIT  = 2'd3
    } state_t;

    localparam logic [7:0] BURST_LEN  = 8'(VID_BURST);
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    state_t      state_q;
    logic        owner_vid_q;
    logic [7:0]  starve_q;
    logic [7:0]  starve_d;
    logic [7:0]  beat_q;

    logic        rd_q;
    logic        we_q;
    logic [28:0] addr_q;
    logic [63:0] din_q;
    logic [7:0]  be_q;
    logic [7:0]  burstcnt_q;

    logic        vid_valid_q;
    logic [63:0] vid_data_q;
    logic        vid_done_q;
    logic [63:0] cpu_rdata_q;
    logic        cpu_rd_done_q;

    logic        grant_vid_d;
    logic        grant_cpu_d;
    logic        in_issue_d;
    logic        accept_d;
    logic        last_beat_d;

    // Video wins unless the CPU has already been passed over STARVE_MAX times in a row.
    always_comb begin
        grant_vid_d = 1'b0;
        grant_cpu_d = 1'b0;
        starve_d    = starve_q;
        in_issue_d  = (state_q == ISSUE_RD) || (state_q == ISSUE_WR);
        accept_d    = in_issue_d && !bus.ddram_busy;
        last_beat_d = owner_vid_q ? (beat_q == (BURST_LEN - 8'd1)) : 1'b1;

        if (state_q == IDLE) begin
            if (bus.vid_req && !(bus.cpu_req && (starve_q == STARVE_LIM))) begin
                grant_vid_d = 1'b1;
            end else if (bus.cpu_req) begin
                grant_cpu_d = 1'b1;
            end
        end

        if (!bus.cpu_req || grant_cpu_d) begin
            starve_d = 8'd0;
        end else if (grant_vid_d && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            owner_vid_q   <= 1'b0;
            starve_q      <= 8'd0;
            beat_q        <= 8'd0;
            rd_q          <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= 29'd0;
            din_q         <= 64'd0;
            be_q          <= 8'd0;
            burstcnt_q    <= 8'd1;
            vid_valid_q   <= 1'b0;
            vid_data_q    <= 64'd0;
            vid_done_q    <= 1'b0;
            cpu_rdata_q   <= 64'd0;
            cpu_rd_done_q <= 1'b0;
        end else begin
            starve_q      <= starve_d;
            vid_valid_q   <= 1'b0;
            vid_done_q    <= 1'b0;
            cpu_rd_done_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (grant_vid_d) begin
                        owner_vid_q <= 1'b1;
                        rd_q        <= 1'b1;
                        addr_q      <= bus.vid_addr;
                        be_q        <= 8'hFF;
                        burstcnt_q  <= BURST_LEN;
                        state_q     <= ISSUE_RD;
                    end else if (grant_cpu_d) begin
                        owner_vid_q <= 1'b0;
                        addr_q      <= bus.cpu_addr;
                        burstcnt_q  <= 8'd1;
                        if (bus.cpu_we) begin
                            we_q    <= 1'b1;
                            din_q   <= bus.cpu_wdata;
                            be_q    <= bus.cpu_be;
                            state_q <= ISSUE_WR;
                        end else begin
                            rd_q    <= 1'b1;
                            be_q    <= 8'hFF;
                            state_q <= ISSUE_RD;
                        end
                    end
                end

                ISSUE_RD: begin
                    if (accept_d) begin
                        rd_q    <= 1'b0;
                        beat_q  <= 8'd0;
                        state_q <= RD_WAIT;
                    end
                end

                ISSUE_WR: begin
                    if (accept_d) begin
                        we_q    <= 1'b0;
                        state_q <= IDLE;
                    end
                end

                RD_WAIT: begin
                    if (bus.ddram_dout_rdy) begin
                        beat_q <= beat_q + 8'd1;
                        if (owner_vid_q) begin
                            vid_valid_q <= 1'b1;
                            vid_data_q  <= bus.ddram_dout;
                            vid_done_q  <= last_beat_d;
                        end else begin
                            cpu_rdata_q   <= bus.ddram_dout;
                            cpu_rd_done_q <= 1'b1;
                        end
                        if (last_beat_d) begin
                            state_q <= IDLE;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    // Acceptance strobes are combinational so they coincide with the DDRAM accept cycle.
    assign bus.vid_ack        = (state_q == ISSUE_RD) && owner_vid_q && !bus.ddram_busy;
    assign bus.cpu_done       = ((state_q == ISSUE_WR) && !bus.ddram_busy) || cpu_rd_done_q;
    assign bus.vid_valid      = vid_valid_q;
    assign bus.vid_data       = vid_data_q;
    assign bus.vid_done       = vid_done_q;
    assign bus.cpu_rdata      = cpu_rdata_q;
    assign bus.ddram_rd       = rd_q;
    assign bus.ddram_we       = we_q;
    assign bus.ddram_addr     = addr_q;
    assign bus.ddram_din      = din_q;
    assign bus.ddram_be       = be_q;
    assign bus.ddram_burstcnt = burstcnt_q;

`ifdef DDRAM_ARB_STATS_EN
    logic [31:0] vid_grants_q;
    logic [31:0] cpu_grants_q;
    logic [31:0] busy_cycles_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vid_grants_q  <= 32'd0;
            cpu_grants_q  <= 32'd0;
            busy_cycles_q <= 32'd0;
        end else begin
            if (grant_vid_d) begin
                vid_grants_q <= vid_grants_q + 32'd1;
            end
            if (grant_cpu_d) begin
                cpu_grants_q <= cpu_grants_q + 32'd1;
            end
            if (in_issue_d && bus.ddram_busy) begin
                busy_cycles_q <= busy_cycles_q + 32'd1;
            end
        end
    end

    assign stat_vid_grants  = vid_grants_q;
    assign stat_cpu_grants  = cpu_grants_q;
    assign stat_busy_cycles = busy_cycles_q;
`endif

endmodule

// File: tb/tb_ddram_arbiter.sv
// Directed self-checking bench for ddram_arbiter with a simple DDRAM responder model.
// Build with DDRAM_ARB_STATS_EN defined to also exercise the statistics counters.
module tb_ddram_arbiter;

    logic clk;
    logic reset_n;
    int   errCount;
    int   checkCount;

    logic [63:0] memBase;
    int          memLatency;
    logic        memActive;

    ddram_arbiter_if bus();

`ifdef DDRAM_ARB_STATS_EN
    logic [31:0] statVidGrants;
    logic [31:0] statCpuGrants;
    logic [31:0] statBusyCycles;
`endif

    ddram_arbiter #(
        .VID_BURST  (8),
        .STARVE_MAX (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef DDRAM_ARB_STATS_EN
        ,
        .stat_vid_grants  (statVidGrants),
        .stat_cpu_grants  (statCpuGrants),
        .stat_busy_cycles (statBusyCycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DDRAM model: after each accepted read, wait memLatency cycles then return burstcnt beats.
    initial begin
        int nBeats;
        memActive          = 1'b0;
        bus.ddram_dout     = 64'd0;
        bus.ddram_dout_rdy = 1'b0;
        forever begin
            @(posedge clk);
            if (bus.ddram_rd && !bus.ddram_busy) begin
                nBeats    = int'(bus.ddram_burstcnt);
                memActive = 1'b1;
                repeat (memLatency) @(posedge clk);
                for (int i = 0; i < nBeats; i++) begin
                    #1;
                    bus.ddram_dout     = memBase + 64'(i);
                    bus.ddram_dout_rdy = 1'b1;
                    @(posedge clk);
                end
                #1;
                bus.ddram_dout_rdy = 1'b0;
                memActive          = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic vReq, input logic [28:0] vAddr, input logic cReq,
                                 input logic cWe, input logic [28:0] cAddr,
                                 input logic [63:0] cWdata, input logic [7:0] cBe);
        bus.vid_req   = vReq;
        bus.vid_addr  = vAddr;
        bus.cpu_req   = cReq;
        bus.cpu_we    = cWe;
        bus.cpu_addr  = cAddr;
        bus.cpu_wdata = cWdata;
        bus.cpu_be    = cBe;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " rd"},        64'(bus.ddram_rd),       64'd0);
        checkOutput({tag, " we"},        64'(bus.ddram_we),       64'd0);
        checkOutput({tag, " burstcnt"},  64'(bus.ddram_burstcnt), 64'd1);
        checkOutput({tag, " addr"},      64'(bus.ddram_addr),     64'd0);
        checkOutput({tag, " din"},       bus.ddram_din,           64'd0);
        checkOutput({tag, " be"},        64'(bus.ddram_be),       64'd0);
        checkOutput({tag, " vid_ack"},   64'(bus.vid_ack),        64'd0);
        checkOutput({tag, " vid_valid"}, 64'(bus.vid_valid),      64'd0);
        checkOutput({tag, " vid_data"},  bus.vid_data,            64'd0);
        checkOutput({tag, " vid_done"},  64'(bus.vid_done),       64'd0);
        checkOutput({tag, " cpu_done"},  64'(bus.cpu_done),       64'd0);
        checkOutput({tag, " cpu_rdata"}, bus.cpu_rdata,           64'd0);
    endtask

    initial begin
        int beats;
        int doneAt;
        int validCount;
        int doneCycle;
        int grants;
        logic sawDone;

        errCount   = 0;
        checkCount = 0;
        memBase    = 64'd0;
        memLatency = 0;
        reset_n    = 1'b0;
        bus.ddram_busy = 1'b0;
        applyStimulus(1'b0, 29'd0, 1'b0, 1'b0, 29'd0, 64'd0, 8'd0);
        repeat (3) nextCycle();
        checkReset("reset");
        reset_n = 1'b1;
        nextCycle();

        // Video-only burst of 8 beats.
        $display("[TB] video burst");
        applyStimulus(1'b1, 29'h100, 1'b0, 1'b0, 29'd0, 64'd0, 8'd0);
        #1;
        checkOutput("t1 rd before edge", 64'(bus.ddram_rd), 64'd0);
        nextCycle();
        checkOutput("t1 rd", 64'(bus.ddram_rd), 64'd1);
        checkOutput("t1 burstcnt", 64'(bus.ddram_burstcnt), 64'd8);
        checkOutput("t1 addr", 64'(bus.ddram_addr), 64'h100);
        checkOutput("t1 vid_ack", 64'(bus.vid_ack), 64'd1);
        applyStimulus(1'b0, 29'd0, 1'b0, 1'b0, 29'd0, 64'd0, 8'd0);
        nextCycle();
        checkOutput("t1 rd after accept", 64'(bus.ddram_rd), 64'd0);
        checkOutput("t1 vid_ack pulse", 64'(bus.vid_ack), 64'd0);
        beats  = 0;
        doneAt = 0;
        for (int c = 0; c < 40 && doneAt == 0; c++) begin
            nextCycle();
            if (bus.vid_valid) begin
                checkOutput($sformatf("t1 beat%0d data", beats), bus.vid_data, 64'(beats));
                beats++;
            end
            if (bus.vid_done) doneAt = beats;
        end
        checkOutput("t1 beat count", 64'(beats), 64'd8);
        checkOutput("t1 done beat", 64'(doneAt), 64'd8);

        // CPU write stalled by busy for 3 cycles.
        $display("[TB] cpu write with busy");
        nextCycle();
        applyStimulus(1'b0, 29'd0, 1'b1, 1'b1, 29'h20, 64'hDEADBEEF_CAFEF00D, 8'h0F);
        bus.ddram_busy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            bus.ddram_busy = (c < 3);
            #1;
            checkOutput($sformatf("t2 we c%0d", c), 64'(bus.ddram_we), 64'd1);
            checkOutput($sformatf("t2 addr c%0d", c), 64'(bus.ddram_addr), 64'h20);
            checkOutput($sformatf("t2 din c%0d", c), bus.ddram_din, 64'hDEADBEEF_CAFEF00D);
            checkOutput($sformatf("t2 be c%0d", c), 64'(bus.ddram_be), 64'h0F);
            checkOutput($sformatf("t2 burstcnt c%0d", c), 64'(bus.ddram_burstcnt), 64'd1);
            checkOutput($sformatf("t2 cpu_done c%0d", c), 64'(bus.cpu_done), (c == 3) ? 64'd1 : 64'd0);
        end
        nextCycle();
        applyStimulus(1'b0, 29'd0, 1'b0, 1'b0, 29'd0, 64'd0, 8'd0);
        checkOutput("t2 we released", 64'(bus.ddram_we), 64'd0);
        checkOutput("t2 cpu_done pulse", 64'(bus.cpu_done), 64'd0);
`ifdef DDRAM_ARB_STATS_EN
        checkOutput("t2 stat busy", 64'(statBusyCycles), 64'd3);
        checkOutput("t2 stat vid", 64'(statVidGrants), 64'd1);
        checkOutput("t2 stat cpu", 64'(statCpuGrants), 64'd1);
`endif

        // CPU read, memory answers 10 cycles after accept.
        $display("[TB] cpu read");
        nextCycle();
        memBase    = 64'h1234;
        memLatency = 10;
        applyStimulus(1'b0, 29'd0, 1'b1, 1'b0, 29'h55, 64'd0, 8'd0);
        nextCycle();
        checkOutput("t4 rd", 64'(bus.ddram_rd), 64'd1);
        checkOutput("t4 burstcnt", 64'(bus.ddram_burstcnt), 64'd1);
        checkOutput("t4 addr", 64'(bus.ddram_addr), 64'h55);
        checkOutput("t4 vid_ack", 64'(bus.vid_ack), 64'd0);
        validCount = 0;
        doneCycle  = -1;
        for (int c = 0; c < 40 && doneCycle < 0; c++) begin
            nextCycle();
            if (bus.vid_valid) validCount++;
            if (bus.cpu_done) begin
                doneCycle = c;
                checkOutput("t4 cpu_rdata", bus.cpu_rdata, 64'h1234);
                applyStimulus(1'b0, 29'd0, 1'b0, 1'b0, 29'd0, 64'd0, 8'd0);
            end
        end
        checkOutput("t4 done cycle", 64'(doneCycle), 64'd11);
        checkOutput("t4 no vid_valid", 64'(validCount), 64'd0);

        // Both requesters held: V,V,V,V,C repeating.
        $display("[TB] starvation guard");
        reset_n = 1'b0;
        repeat (2) nextCycle();
        reset_n    = 1'b1;
        memBase    = 64'd0;
        memLatency = 0;
        applyStimulus(1'b1, 29'h300, 1'b1, 1'b1, 29'h40, 64'h55, 8'hFF);
        grants = 0;
        for (int c = 0; c < 600 && grants < 10; c++) begin
            nextCycle();
            if (bus.vid_ack || bus.cpu_done) begin
                checkOutput($sformatf("t3 grant%0d is cpu", grants), 64'(bus.cpu_done),
                            (grants % 5 == 4) ? 64'd1 : 64'd0);
                grants++;
`ifdef DDRAM_ARB_STATS_EN
                if (grants == 10) begin
                    checkOutput("t6 stat vid", 64'(statVidGrants), 64'd8);
                    checkOutput("t6 stat cpu", 64'(statCpuGrants), 64'd2);
                end
`endif
            end
        end
        checkOutput("t3 grant count", 64'(grants), 64'd10);
        applyStimulus(1'b0, 29'd0, 1'b0, 1'b0, 29'd0, 64'd0, 8'd0);
        for (int c = 0; c < 30 && memActive; c++) nextCycle();
        repeat (2) nextCycle();

        // Reset in the middle of a video burst.
        $display("[TB] reset mid-burst");
        memBase = 64'h500;
        applyStimulus(1'b1, 29'h400, 1'b0, 1'b0, 29'd0, 64'd0, 8'd0);
        validCount = 0;
        for (int c = 0; c < 30 && validCount < 3; c++) begin
            nextCycle();
            if (bus.vid_ack) applyStimulus(1'b0, 29'd0, 1'b0, 1'b0, 29'd0, 64'd0, 8'd0);
            if (bus.vid_valid) validCount++;
        end
        checkOutput("t5 beats before reset", 64'(validCount), 64'd3);
        reset_n = 1'b0;
        nextCycle();
        checkReset("t5 after reset");
        checkOutput("t5 strays pending", 64'(memActive), 64'd1);
        reset_n    = 1'b1;
        validCount = 0;
        for (int c = 0; c < 30 && memActive; c++) begin
            nextCycle();
            if (bus.vid_valid || bus.vid_done) validCount++;
        end
        nextCycle();
        checkOutput("t5 stray vid_valid", 64'(validCount), 64'd0);
        memBase    = 64'h9999;
        memLatency = 2;
        applyStimulus(1'b0, 29'd0, 1'b1, 1'b0, 29'h66, 64'd0, 8'd0);
        sawDone = 1'b0;
        for (int c = 0; c < 40 && !sawDone; c++) begin
            nextCycle();
            if (bus.cpu_done) begin
                sawDone = 1'b1;
                checkOutput("t5 cpu_rdata", bus.cpu_rdata, 64'h9999);
                applyStimulus(1'b0, 29'd0, 1'b0, 1'b0, 29'd0, 64'd0, 8'd0);
            end
        end
        checkOutput("t5 cpu served", 64'(sawDone), 64'd1);

        repeat (3) nextCycle();
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
